i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
Output-side serializer for the trumpet DSP chain. Accepts processed 16-bit signed samples from audio_processor.out_sample through a valid/ready handshake and buffers them in a small FIFO. Drives a standard Philips I2S stream (BCLK, LRCLK, SDATA) to an external DAC. Mono: each sample is sent on both left and right channels.

Parameters:
DATA_W, 16, sample width in bits; the frame format is fixed at 2 x 16 slots.
CLK_DIV, 2, clk cycles per BCLK half-period; BCLK = clk/(2*CLK_DIV); sample rate = clk/(64*CLK_DIV).
FIFO_DEPTH, 4, sample FIFO depth; must be a power of two and at least 2.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  1 = pop and transmit samples; 0 = mute, with clocks still running
in_sample  in  16  signed sample, two's complement
in_valid  in  1  in_sample is valid
in_ready  out  1  FIFO can accept a sample (= !full)
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left, 1 = right
i2s_sdata  out  1  serial data, MSB first
underrun  out  1  one-clk pulse when a load finds the FIFO empty while enable=1

Behaviour:
- Reset (rst_n=0 at a clk edge): bclk=0, lrclk=0, sdata=0, underrun=0, in_ready=1, fifo_level=0. Divider, bit counter, shift register and FIFO pointers are cleared. Reset mid-frame aborts the frame; buffered samples are discarded.
- Divider: div_cnt counts 0..CLK_DIV-1. At terminal count, bclk toggles and div_cnt returns to 0. The first bclk rise occurs CLK_DIV clks after reset release.
- All serial outputs update only on the clk edge where bclk goes 1->0 (a "fall event"). They are stable across the following bclk rise, where the DAC samples them.
- bit_cnt (5 bits) increments by 1 on each fall event and wraps 31->0.
  - lrclk = 0 when the new bit_cnt is in 0..15; lrclk = 1 when it is in 16..31.
- I2S one-bit delay: on the fall event where the new bit_cnt = 1, load shreg = {w, w} (32 bits) and drive sdata = w[15].
  - Each subsequent fall event shifts shreg left by 1; sdata = new shreg MSB.
  - Left MSB..LSB occupy slots 1..16; right MSB..LSB occupy slots 17..31 and slot 0 of the next frame.
- Word selection at a load (new bit_cnt = 1):
  - enable=1 and FIFO non-empty: w = FIFO head; the head is popped in that clk.
  - enable=1 and FIFO empty: w = 0; underrun=1 for exactly that clk; no pop.
  - enable=0: w = 0; no pop; no underrun.
- enable changes take effect only at the next load; a frame in progress completes unchanged.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full, registered from the current level.
  - Push and pop in the same clk: level unchanged, and both operations are done.
  - When full, in_ready stays 0 in the pop clk and rises in the following clk.
  - Pop is decided from the registered level. If the FIFO is empty in a load clk, underrun fires even if a push lands in the same clk; the pushed word is kept for the next frame.
  - fifo_level saturates naturally at FIFO_DEPTH; no overflow is possible.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a sample pushed into an empty FIFO reaches sdata at the next load event. Worst case is 64*CLK_DIV + 1 clks.
- No arithmetic is applied to the data: bits are sent verbatim. 0x8000 is sent as 1 followed by fifteen 0s.

Test Plan:
1. Reset: hold rst_n=0 for 5 clks with in_valid=1 -> during reset and the first clk after: all outputs 0, in_ready=1, fifo_level=0, no push accepted while in reset.
2. Basic frame, CLK_DIV=2, enable=1: push 0xA5C3 -> at bclk rises, slots 1..16 read 1010010111000011 with lrclk=0; slots 17..31 plus next slot 0 read the same bits with lrclk=1. BCLK period is 4 clks; frame is 128 clks; fifo_level returns to 0 at the load.
3. Underrun: enable=1 with empty FIFO -> underrun high for exactly 1 clk at each load (every 128 clks); sdata=0 for the whole frame; lrclk keeps toggling every 64 clks.
4. Back-pressure: FIFO_DEPTH=4, in_valid held with samples 1..5 before any load -> in_ready drops after the 4th push, the 5th is held; fifo_level=4. After the next load: level 3, 5th accepted on the following clk, level 4.
5. Mute: fifo_level=2, enable=0 across two frames -> sdata=0, level stays 2, underrun never pulses. Raise enable -> next load pops, level 1, that sample appears on the wire.
6. Extremes and mid-frame reset: push 0x8000 then 0x7FFF -> slots read 1000000000000000 then 0111111111111111 on both channels. Assert rst_n=0 at slot 9 of the second frame -> next clk: all outputs 0, level 0; after release, the frame restarts at bit_cnt 0.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: mono Philips-I2S serializer for the trumpet DSP output stage.
// Samples enter through a valid/ready FIFO. Each popped sample is sent on both
// the left and right slots of a 2 x 16-bit frame.
module i2s_dac_tx #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic                          underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DIV_W-1:0]    div_cnt;
  logic [4:0]          bit_cnt;
  logic [4:0]          bit_cnt_nxt;
  logic [2*DATA_W-1:0] shreg;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      level;
  logic [DATA_W-1:0]   load_word;
  logic                tick;
  logic                fall_evt;
  logic                load;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  // A load happens on the fall event that moves the bit counter onto slot 1.
  // Slot 0 carries the previous right LSB; this is the one-bit I2S delay.
  assign tick        = (div_cnt == DIV_LAST);
  assign fall_evt    = tick && i2s_bclk;
  assign bit_cnt_nxt = bit_cnt + 5'd1;
  assign load        = fall_evt && (bit_cnt_nxt == 5'd1);

  // Push and pop are both decided from the registered occupancy.
  // An empty FIFO at a load therefore underruns even if a push lands in that clk.
  assign fifo_empty = (level == '0);
  assign in_ready   = (level != LEVEL_FULL);
  assign push       = in_valid && in_ready;
  assign pop        = load && enable && !fifo_empty;
  assign fifo_level = level;

  // Select the word for the coming frame: the FIFO head when popping, otherwise silence.
  always_comb begin
    load_word = '0;
    if (pop) begin
      load_word = mem[rd_ptr];
    end
  end

  // Bit-clock divider: toggle bclk every CLK_DIV clks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Serial outputs change only on bclk falls, so they are stable when the DAC samples on the rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt   <= bit_cnt_nxt;
      i2s_lrclk <= bit_cnt_nxt[4];
      if (load) begin
        shreg     <= {load_word, load_word};
        i2s_sdata <= load_word[DATA_W-1];
      end else begin
        shreg     <= {shreg[2*DATA_W-2:0], 1'b0};
        i2s_sdata <= shreg[2*DATA_W-2];
      end
    end
  end

  // Flag a starved load with a one-clk pulse; a muted load is not a starved load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= load && enable && fifo_empty;
    end
  end

  // FIFO pointers and occupancy; the pointers wrap because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (PTR_W + 1)'(1);
        2'b01:   level <= level - (PTR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Sample storage; it needs no reset because the occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_sample;
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: scoreboard bench for the I2S serializer.
// A reference model uses frame arithmetic and a sample queue. At each load it
// pushes the expected word. A monitor rebuilds words from the wire and pops
// the expectations to compare them.
module tb_i2s_dac_tx;

  localparam int DATA_W      = 16;
  localparam int CLK_DIV     = 2;
  localparam int DEPTH       = 4;
  localparam int LOAD_BOUND  = 400;
  localparam int READY_BOUND = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fifo_level;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          t = 0;
  int          load_cnt = 0;
  bit          started = 1'b0;
  bit          m_rst = 1'b0;
  bit          m_underrun = 1'b0;
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];

  // Wire monitor state
  int          rise_cnt = 0;
  logic        prev_bclk = 1'b0;
  logic [15:0] left_w = '0;
  logic [15:0] right_w = '0;

  i2s_dac_tx #(
    .DATA_W(DATA_W),
    .CLK_DIV(CLK_DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .in_sample(in_sample),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fifo_level(fifo_level),
    .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .underrun(underrun)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame position comes from the clk count since reset.
  // The FIFO is a plain queue.
  always @(posedge clk) begin
    int          sz;
    logic [15:0] w;
    if (!rst_n) begin
      t          = 0;
      mq.delete();
      m_underrun = 1'b0;
      m_rst      = 1'b1;
      started    = 1'b1;
    end else begin
      m_rst      = 1'b0;
      t          = t + 1;
      sz         = mq.size();
      m_underrun = 1'b0;
      if ((t % (2 * CLK_DIV) == 0) && ((t / (2 * CLK_DIV)) % 32 == 1)) begin
        if (enable && sz != 0) begin
          w = mq.pop_front();
        end else begin
          w          = 16'h0000;
          m_underrun = enable;
        end
        exp_q.push_back(w);
        load_cnt++;
      end
      if (in_valid && sz != DEPTH) begin
        mq.push_back(in_sample);
      end
    end
  end

  // Per-clk checks of clocks, flow control and the underrun pulse against the model.
  always @(negedge clk) begin
    if (started) begin
      if (m_rst) begin
        checkOutput("reset bclk", i2s_bclk, 0);
        checkOutput("reset lrclk", i2s_lrclk, 0);
        checkOutput("reset sdata", i2s_sdata, 0);
        checkOutput("reset underrun", underrun, 0);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset fifo_level", fifo_level, 0);
      end else begin
        checkOutput("bclk", i2s_bclk, (t / CLK_DIV) % 2);
        checkOutput("lrclk", i2s_lrclk, (((t / (2 * CLK_DIV)) % 32) >= 16) ? 1 : 0);
        checkOutput("in_ready", in_ready, (mq.size() != DEPTH) ? 1 : 0);
        checkOutput("fifo_level", fifo_level, mq.size());
        checkOutput("underrun", underrun, m_underrun);
      end
    end
  end

  // Monitor: rebuild left/right words at bclk rises and compare them once a frame is complete.
  always @(negedge clk) begin
    int          slot;
    logic [15:0] w;
    if (started) begin
      if (m_rst) begin
        rise_cnt  = 0;
        prev_bclk = 1'b0;
        left_w    = '0;
        right_w   = '0;
        exp_q.delete();
      end else begin
        if (i2s_bclk && !prev_bclk) begin
          slot = rise_cnt % 32;
          if (slot >= 1 && slot <= 16) begin
            left_w = {left_w[14:0], i2s_sdata};
          end else begin
            right_w = {right_w[14:0], i2s_sdata};
          end
          if (slot == 0 && rise_cnt >= 32) begin
            if (exp_q.size() == 0) begin
              checkOutput("scoreboard has entry", 0, 1);
            end else begin
              w = exp_q.pop_front();
              checkOutput("left word", left_w, w);
              checkOutput("right word", right_w, w);
            end
          end
          rise_cnt++;
        end
        prev_bclk = i2s_bclk;
      end
    end
  end

  // Offer one sample and hold it until the handshake completes; in_valid stays high on return.
  task automatic applyStimulus(input logic [15:0] w);
    bit done = 1'b0;
    in_sample = w;
    in_valid  = 1'b1;
    for (int i = 0; i < READY_BOUND; i++) begin
      if (in_ready === 1'b1) begin
        @(negedge clk);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL push accept: got no handshake, expected one within %0d clks", READY_BOUND);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic waitLoad();
    int start;
    bit seen;
    start = load_cnt;
    seen  = 1'b0;
    for (int i = 0; i < LOAD_BOUND; i++) begin
      @(negedge clk);
      if (load_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL load wait: got no load, expected one within %0d clks", LOAD_BOUND);
    end
  endtask

  // Directed scenarios first, then a randomized run, then a drain and the summary.
  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b1;
    in_sample = 16'($urandom);
    repeat (5) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Basic frame, followed by two starved frames
    applyStimulus(16'hA5C3);
    idle();
    waitLoad();
    waitLoad();
    waitLoad();

    // Back-pressure: five samples offered right after a load
    waitLoad();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(16'(i));
    end
    idle();

    // Mute with two samples buffered, then unmute
    for (int k = 0; k < 6 && mq.size() > 2; k++) begin
      waitLoad();
    end
    enable = 1'b0;
    waitLoad();
    waitLoad();
    waitLoad();
    enable = 1'b1;
    waitLoad();
    waitLoad();
    waitLoad();

    // Extreme values, then a reset in the middle of a frame
    applyStimulus(16'h8000);
    applyStimulus(16'h7FFF);
    applyStimulus(16'h1234);
    idle();
    waitLoad();
    waitLoad();
    waitLoad();
    repeat (32) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional mute periods
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 150)) @(negedge clk);
      enable = ($urandom_range(0, 4) != 0);
      if (mq.size() == DEPTH) begin
        enable = 1'b1;
      end
      applyStimulus(16'($urandom));
      idle();
    end

    // Drain so that every buffered sample reaches the wire and is compared
    enable = 1'b1;
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      waitLoad();
    end
    waitLoad();
    waitLoad();
    checkOutput("model drained", mq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
